// File: rtl/step_driver.sv
// Step-sequencer timebase: converts Bpm into sixteenth-note Step pulses,
// arms the loop counter with nStart and ends playback when Play drops.
module step_driver #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned STEPS  = 16,
  parameter int unsigned ACC_W  = 32
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Go,
  input  logic       Stop,
  input  logic [7:0] Bpm,
  input  logic       Play,
  output logic       nStart,
  output logic       Step,
  output logic [3:0] StepIdx,
  output logic       Running,
  output logic       BarEnd,
  output logic       Done
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned SUM_W = ACC_W + 1;
  // One sixteenth note lasts 15*CLK_HZ/Bpm cycles; the accumulator counts in Bpm units.
  localparam logic [SUM_W-1:0] THRESH   = SUM_W'(64'(CLK_HZ) * 64'd15);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM0 = 3'd1,
    S_ARM1 = 3'd2,
    S_ARM2 = 3'd3,
    S_RUN  = 3'd4
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               play_s1;
  logic               play_s2;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_d;
  logic [SUM_W-1:0]   acc_sum;
  logic               fire;
  logic               stop_hit;
  logic               n_start_d;
  logic               step_d;
  logic [IDX_W-1:0]   idx_d;
  logic               running_d;
  logic               bar_end_d;
  logic               done_d;

  assign acc_sum  = {1'b0, acc_q} + SUM_W'(Bpm);
  assign fire     = (state_q == S_RUN) && (acc_sum >= THRESH);
  assign stop_hit = Stop && (state_q != S_IDLE);

  // Play comes straight from the loop counter's asynchronous set/clear.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      play_s1 <= 1'b0;
      play_s2 <= 1'b0;
    end else begin
      play_s1 <= Play;
      play_s2 <= play_s1;
    end
  end

  // State, accumulator and registered outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      nStart  <= 1'b1;
      Step    <= 1'b0;
      StepIdx <= '0;
      Running <= 1'b0;
      BarEnd  <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      nStart  <= n_start_d;
      Step    <= step_d;
      StepIdx <= idx_d;
      Running <= running_d;
      BarEnd  <= bar_end_d;
      Done    <= done_d;
    end
  end

  // Next-state logic; Stop overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (Go && !Stop) state_d = S_ARM0;
      S_ARM0: state_d = S_ARM1;
      S_ARM1: state_d = S_ARM2;
      S_ARM2: state_d = S_RUN;
      S_RUN:  if (!play_s2 && !fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (stop_hit) state_d = S_IDLE;
  end

  // Next values for the registered outputs and the phase accumulator.
  always_comb begin
    n_start_d = 1'b1;
    step_d    = 1'b0;
    bar_end_d = 1'b0;
    done_d    = 1'b0;
    idx_d     = StepIdx;
    running_d = Running;
    acc_d     = acc_q;
    unique case (state_q)
      S_IDLE: begin
        if (Go && !Stop) begin
          n_start_d = 1'b0;
          running_d = 1'b1;
          idx_d     = '0;
          acc_d     = '0;
        end
      end
      S_RUN: begin
        if (fire) begin
          // Carry the remainder forward so the mean period stays exactly THRESH/Bpm.
          acc_d     = ACC_W'(acc_sum - THRESH);
          step_d    = 1'b1;
          bar_end_d = (StepIdx == LAST_IDX);
          idx_d     = (StepIdx == LAST_IDX) ? '0 : StepIdx + IDX_W'(1);
        end else begin
          acc_d = ACC_W'(acc_sum);
          if (!play_s2) begin
            done_d    = 1'b1;
            idx_d     = '0;
            running_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
    if (stop_hit) begin
      n_start_d = 1'b1;
      step_d    = 1'b0;
      bar_end_d = 1'b0;
      done_d    = 1'b0;
      idx_d     = '0;
      running_d = 1'b0;
      acc_d     = '0;
    end
  end

endmodule

// File: tb/tb_step_driver.sv
// Scoreboard bench for step_driver: expected nStart/Step/Done events are queued
// with their cycle, index and BarEnd; a negedge monitor pops and compares them.
module tb_step_driver;

  localparam int unsigned CLK_HZ = 1000;

  logic       Clock  = 1'b0;
  logic       Resetn = 1'b0;
  logic       Go     = 1'b0;
  logic       Stop   = 1'b0;
  logic [7:0] Bpm    = 8'd0;
  logic       Play   = 1'b0;
  logic       nStart;
  logic       Step;
  logic [3:0] StepIdx;
  logic       Running;
  logic       BarEnd;
  logic       Done;

  step_driver #(.CLK_HZ(CLK_HZ), .STEPS(16), .ACC_W(32)) dut (
    .Clock(Clock), .Resetn(Resetn), .Go(Go), .Stop(Stop), .Bpm(Bpm), .Play(Play),
    .nStart(nStart), .Step(Step), .StepIdx(StepIdx), .Running(Running),
    .BarEnd(BarEnd), .Done(Done)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int kind;   // 0 = nStart low, 1 = Step, 2 = Done
    int cyc;
    int idx;
    bit bar;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int idx, input bit bar);
    ev_t e;
    e.kind = kind; e.cyc = c; e.idx = idx; e.bar = bar;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d required none (cyc %0d)", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("ev%0d_kind", e.kind), kind, e.kind);
      check($sformatf("ev%0d_cycle", e.kind), cyc, e.cyc);
      check($sformatf("ev%0d_idx", e.kind), int'(StepIdx), e.idx);
      check($sformatf("ev%0d_barend", e.kind), int'(BarEnd), int'(e.bar));
    end
  endtask

  // Monitor: every visible output event must match the head of the queue.
  always @(negedge Clock) begin
    if (Resetn) begin
      if (!nStart) pop_cmp(0);
      if (Step)    pop_cmp(1);
      if (Done)    pop_cmp(2);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Pulse Go for one cycle from a negedge; returns the launch cycle g (nStart at g+1).
  task automatic go(output int g);
    g = cyc;
    push(0, g + 1, 0, 1'b0);
    Go = 1'b1;
    tick(1);
    Go = 1'b0;
  endtask

  task automatic stop_pulse(input string name);
    Stop = 1'b1;
    tick(1);
    Stop = 1'b0;
    check({name, "_running"}, int'(Running), 0);
    check({name, "_idx"}, int'(StepIdx), 0);
  endtask

  int t2_n[7] = '{2143, 4286, 6429, 8572, 10715, 12858, 15000};

  initial begin
    int g;
    int nsteps;
    bit done_seen;

    tick(2);
    check("reset_outputs", int'({nStart, Step, StepIdx, Running, BarEnd, Done}), 9'b1_0_0000_000);
    Resetn = 1'b1;
    tick(2);
    check("idle_running", int'(Running), 0);

    // T1: Bpm=150 -> Step every 100 cycles, index wraps after 16 with BarEnd.
    Play = 1'b1;
    Bpm  = 8'd150;
    go(g);
    check("t1_running_arm0", int'(Running), 1);
    for (int k = 1; k <= 17; k++) push(1, g + 4 + 100 * k, k % 16, k == 16);
    tick(1703);
    stop_pulse("t1_stop");

    // T2: Bpm=7 -> uneven spacing, seven Steps in exactly 15000 RUN cycles.
    Bpm = 8'd7;
    go(g);
    for (int k = 0; k < 7; k++) push(1, g + 4 + t2_n[k], k + 1, 1'b0);
    tick(15003);
    stop_pulse("t2_stop");

    // T4: Stop during the cycle whose accumulation reaches THRESH.
    Bpm = 8'd150;
    go(g);
    tick(102);
    Stop = 1'b1;
    tick(1);
    Stop = 1'b0;
    check("t4_step", int'(Step), 0);
    check("t4_running", int'(Running), 0);
    check("t4_done", int'(Done), 0);
    check("t4_nstart", int'(nStart), 1);
    tick(150);

    // T5: pause for 50 cycles mid-phase; the pause shifts later Steps by exactly 50.
    go(g);
    push(1, g + 104, 1, 1'b0);
    push(1, g + 254, 2, 1'b0);
    push(1, g + 354, 3, 1'b0);
    tick(129);
    Bpm = 8'd0;
    tick(50);
    check("t5_paused_running", int'(Running), 1);
    Bpm = 8'd150;
    tick(174);
    stop_pulse("t5_stop");

    // T3: loop-counter model, one loop of 16 Steps, then Play drops.
    Play = 1'b0;
    go(g);
    if (!nStart) Play = 1'b1;
    for (int k = 1; k <= 16; k++) push(1, g + 4 + 100 * k, k % 16, k == 16);
    push(2, g + 1607, 0, 1'b0);
    nsteps    = 0;
    done_seen = 1'b0;
    for (int i = 0; i < 1800 && !done_seen; i++) begin
      tick(1);
      if (!nStart) Play = 1'b1;
      if (Step) begin
        nsteps++;
        if (nsteps == 16) Play = 1'b0;
      end
      if (Done) done_seen = 1'b1;
    end
    check("t3_done_seen", int'(done_seen), 1);
    check("t3_steps", nsteps, 16);
    check("t3_running", int'(Running), 0);
    check("t3_idx", int'(StepIdx), 0);
    tick(1);
    check("t3_done_width", int'(Done), 0);

    // T6: Go while running is ignored; async reset mid-RUN clears outputs at once.
    Play = 1'b1;
    go(g);
    push(1, g + 104, 1, 1'b0);
    tick(48);
    Go = 1'b1;
    tick(1);
    Go = 1'b0;
    check("t6_running", int'(Running), 1);
    tick(100);
    Resetn = 1'b0;
    #1;
    check("t6_async_reset", int'({nStart, Step, StepIdx, Running, BarEnd, Done}), 9'b1_0_0000_000);
    tick(2);
    Resetn = 1'b1;
    tick(3);
    check("t6_after_reset", int'(Running), 0);

    // Go and Stop together in IDLE must not start.
    Go   = 1'b1;
    Stop = 1'b1;
    tick(1);
    Go   = 1'b0;
    Stop = 1'b0;
    tick(3);
    check("go_stop_idle", int'(Running), 0);

    tick(5);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
